// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
//   Feeds an HD44780-style LCD write controller. It holds a 2x16 character
//   buffer written by the host. After reset it waits for the panel to power
//   up and sends the init commands. It then resends the whole buffer whenever
//   the buffer changes, and waits the LCD execution delay after each transfer.
//
// Ports
//   iCLK, iRST_N       clock, asynchronous active-low reset
//   iWR_EN/ADDR/CHAR   host buffer write (0-15 line 1, 16-31 line 2)
//   oLCD_DATA/RS       byte and register select to the controller
//   oLCD_START         transfer request, held until iLCD_DONE rises
//   iLCD_DONE          controller completion (rising edge is used)
//   oInitDone          init sequence finished
//   oBusy              transfer or delay in progress
module lcd_text_sequencer #(
   parameter int PWR_DELAY = 750000,
   parameter int CMD_DELAY = 2000,
   parameter int CLR_DELAY = 82000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iWR_EN,
   input  logic [4:0] iWR_ADDR,
   input  logic [7:0] iWR_CHAR,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE,
   output logic       oInitDone,
   output logic       oBusy
);

   localparam logic [2:0] PWR_WAIT = 3'd0;
   localparam logic [2:0] LOAD     = 3'd1;
   localparam logic [2:0] STROBE   = 3'd2;
   localparam logic [2:0] GAP      = 3'd3;
   localparam logic [2:0] IDLE     = 3'd4;

   localparam logic [19:0] PWR_LIM = 20'(PWR_DELAY - 1);
   localparam logic [19:0] CMD_LIM = 20'(CMD_DELAY - 1);
   localparam logic [19:0] CLR_LIM = 20'(CLR_DELAY - 1);

   logic [2:0]       state_q, state_d;
   logic [31:0][7:0] buf_q;
   logic             dirty_q, dirty_d;
   logic [19:0]      cnt_q, cnt_d;
   logic             done_d_q;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             start_q, start_d;
   logic             init_done_q, init_done_d;
   logic             init_mode_q, init_mode_d;   // 1 = walking the init list
   logic [5:0]       idx_q, idx_d;               // item pointer within the list

   logic [7:0]  item_data;
   logic        item_rs;
   logic [4:0]  bidx;
   logic        last_item;
   logic [19:0] gap_lim;
   logic        done_rise;
   logic        dirty_clr;

   // Refresh list: 0 = 0x80, 1..16 = buf[0..15], 17 = 0xC0, 18..33 = buf[16..31].
   // The subtraction wraps in 5 bits, which maps 18..33 onto 16..31.
   always_comb begin
      bidx = idx_q[4:0] - ((idx_q < 6'd17) ? 5'd1 : 5'd2);
      item_data = 8'h00;
      item_rs   = 1'b0;
      if (init_mode_q) begin
         case (idx_q[1:0])
            2'd0:    item_data = 8'h38;
            2'd1:    item_data = 8'h0C;
            2'd2:    item_data = 8'h01;
            default: item_data = 8'h06;
         endcase
      end else if (idx_q == 6'd0) begin
         item_data = 8'h80;
      end else if (idx_q == 6'd17) begin
         item_data = 8'hC0;
      end else begin
         item_data = buf_q[bidx];
         item_rs   = 1'b1;
      end
   end

   assign last_item = init_mode_q ? (idx_q == 6'd3) : (idx_q == 6'd33);
   // The byte just sent is still held in data_q/rs_q while in GAP.
   assign gap_lim   = (!rs_q && data_q == 8'h01) ? CLR_LIM : CMD_LIM;
   // Only a 0->1 transition counts, so a level left high is ignored.
   assign done_rise = iLCD_DONE & ~done_d_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      rs_d        = rs_q;
      start_d     = start_q;
      init_done_d = init_done_q;
      init_mode_d = init_mode_q;
      idx_d       = idx_q;
      dirty_clr   = 1'b0;
      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWR_LIM) begin
               state_d     = LOAD;
               idx_d       = 6'd0;
               init_mode_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         LOAD: begin
            data_d  = item_data;
            rs_d    = item_rs;
            start_d = 1'b1;
            state_d = STROBE;
         end
         STROBE: begin
            if (done_rise) begin
               start_d = 1'b0;
               cnt_d   = 20'd0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == gap_lim) begin
               if (last_item) begin
                  state_d     = IDLE;
                  init_done_d = 1'b1;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = LOAD;
               end
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         IDLE: begin
            if (dirty_q) begin
               dirty_clr   = 1'b1;
               idx_d       = 6'd0;
               init_mode_d = 1'b0;
               state_d     = LOAD;
            end
         end
         default: state_d = PWR_WAIT;
      endcase
      // A host write in the same cycle as the clear wins, forcing another pass.
      dirty_d = iWR_EN ? 1'b1 : (dirty_clr ? 1'b0 : dirty_q);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= PWR_WAIT;
         buf_q       <= {32{8'h20}};
         dirty_q     <= 1'b1;
         cnt_q       <= 20'd0;
         done_d_q    <= 1'b0;
         data_q      <= 8'h00;
         rs_q        <= 1'b0;
         start_q     <= 1'b0;
         init_done_q <= 1'b0;
         init_mode_q <= 1'b1;
         idx_q       <= 6'd0;
      end else begin
         state_q     <= state_d;
         dirty_q     <= dirty_d;
         cnt_q       <= cnt_d;
         done_d_q    <= iLCD_DONE;
         data_q      <= data_d;
         rs_q        <= rs_d;
         start_q     <= start_d;
         init_done_q <= init_done_d;
         init_mode_q <= init_mode_d;
         idx_q       <= idx_d;
         if (iWR_EN) buf_q[iWR_ADDR] <= iWR_CHAR;
      end
   end

   // In LOAD the item is presented combinationally so it is valid for a full
   // cycle before oLCD_START rises. After LOAD it is held in data_q/rs_q.
   assign oLCD_DATA  = (state_q == LOAD) ? item_data : data_q;
   assign oLCD_RS    = (state_q == LOAD) ? item_rs   : rs_q;
   assign oLCD_START = start_q;
   assign oInitDone  = init_done_q;
   assign oBusy      = (state_q != IDLE);

endmodule
